// File: rtl/pdm_mix_scheduler.sv
// pdm_mix_scheduler
//
// Mixes the per-channel amplitude samples of the AY-8913 tone/noise/envelope
// channels into one value for the sigma-delta (PDM) modulator. Each channel
// hands over samples on a valid/ready handshake into a one-deep holding
// register. Once every SAMPLE_DIV clocks, a single shared adder walks the
// channels one per cycle. The sum is then saturated and, when mute is high,
// forced toward zero. The result is slew-limited by RAMP_STEP and presented on
// pdm_value together with a one-cycle sample_strobe.
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-high reset
//   ch_valid      per-channel sample valid
//   ch_data       channel i sample at bits [i*VALUE_BITS +: VALUE_BITS]
//   ch_ready      per-channel ready (high while the holding register is free)
//   mute          level; ramps the output toward 0 while high (sampled at update)
//   pdm_value     registered value to the PDM modulator
//   sample_strobe one-cycle pulse when pdm_value updates
//   busy          high while the mixer is summing or updating
module pdm_mix_scheduler #(
    parameter int VALUE_BITS = 8,
    parameter int NUM_CH     = 3,
    parameter int SAMPLE_DIV = 64,
    parameter int RAMP_STEP  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH-1:0]            ch_valid,
    input  logic [NUM_CH*VALUE_BITS-1:0] ch_data,
    output logic [NUM_CH-1:0]            ch_ready,
    input  logic                         mute,
    output logic [VALUE_BITS-1:0]        pdm_value,
    output logic                         sample_strobe,
    output logic                         busy
);

    localparam int ACC_W = VALUE_BITS + $clog2(NUM_CH);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int STEP_CLAMP = (RAMP_STEP >= 2**VALUE_BITS) ? 2**VALUE_BITS : RAMP_STEP;

    localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_CH - 1);
    localparam logic [ACC_W-1:0]      MAX_VAL  = ACC_W'(2**VALUE_BITS - 1);
    localparam logic [VALUE_BITS:0]   STEP     = (VALUE_BITS+1)'(STEP_CLAMP);

    typedef enum logic [1:0] {
        IDLE,
        SUM,
        UPDATE
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [DIV_W-1:0]        div_cnt;
    logic                    tick;
    logic [IDX_W-1:0]        idx;
    logic [ACC_W-1:0]        acc;
    logic [VALUE_BITS-1:0]   held [NUM_CH];
    logic [NUM_CH-1:0]       pending;

    // Clamp the mixed sum to the output range.
    function automatic logic [VALUE_BITS-1:0] saturate(input logic [ACC_W-1:0] a);
        if (a > MAX_VAL)
            return '1;
        return a[VALUE_BITS-1:0];
    endfunction

    // Move cur toward tgt by at most STEP; a zero step jumps straight to tgt.
    function automatic logic [VALUE_BITS-1:0] ramp(input logic [VALUE_BITS-1:0] cur,
                                                   input logic [VALUE_BITS-1:0] tgt);
        logic [VALUE_BITS:0] diff;
        if (RAMP_STEP == 0)
            return tgt;
        if (tgt >= cur) begin
            diff = {1'b0, tgt} - {1'b0, cur};
            if (diff > STEP)
                return cur + STEP[VALUE_BITS-1:0];
            return tgt;
        end
        diff = {1'b0, cur} - {1'b0, tgt};
        if (diff > STEP)
            return cur - STEP[VALUE_BITS-1:0];
        return tgt;
    endfunction

    assign tick     = (div_cnt == DIV_LAST);
    assign ch_ready = ~pending;
    assign busy     = (state != IDLE);

    // Free-running sample divider.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            div_cnt <= '0;
        else if (tick)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (tick) state_nxt = SUM;
            SUM:     if (idx == IDX_LAST) state_nxt = UPDATE;
            UPDATE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Holding registers, shared adder and output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx           <= '0;
            acc           <= '0;
            pending       <= '0;
            pdm_value     <= '0;
            sample_strobe <= 1'b0;
            for (int i = 0; i < NUM_CH; i++)
                held[i] <= '0;
        end else begin
            sample_strobe <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick) begin
                        idx <= '0;
                        acc <= '0;
                    end
                end
                SUM: begin
                    acc          <= acc + ACC_W'(held[idx]);
                    pending[idx] <= 1'b0;
                    idx          <= idx + 1'b1;
                end
                UPDATE: begin
                    pdm_value     <= ramp(pdm_value, mute ? '0 : saturate(acc));
                    sample_strobe <= 1'b1;
                end
                default: ;
            endcase
            // An accept only happens while pending is clear, so the later
            // assignment here never fights a SUM clear of a pending sample;
            // it just lets a same-cycle new sample win.
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_valid[i] && !pending[i]) begin
                    held[i]    <= ch_data[i*VALUE_BITS +: VALUE_BITS];
                    pending[i] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pdm_mix_scheduler.sv
// Directed testbench for pdm_mix_scheduler. Two instances share all inputs:
// one jumps straight to its target (RAMP_STEP=0), the other slews by 4.
// Cycle n is the clock period after the n-th rising edge following reset
// release; with SAMPLE_DIV=16 the tick falls in cycle 15 and strobes land
// in cycles 20, 36, 52, ...
module tb_pdm_mix_scheduler;

    localparam int VB  = 8;
    localparam int NCH = 3;
    localparam int DIV = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [NCH-1:0]    ch_valid;
    logic [NCH*VB-1:0] ch_data;
    logic              mute;

    logic [NCH-1:0]    ready_j, ready_r;
    logic [VB-1:0]     pdm_j, pdm_r;
    logic              strobe_j, strobe_r;
    logic              busy_j, busy_r;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pdm_mix_scheduler #(.VALUE_BITS(VB), .NUM_CH(NCH), .SAMPLE_DIV(DIV), .RAMP_STEP(0)) dut_jump (
        .clk(clk), .reset(reset), .ch_valid(ch_valid), .ch_data(ch_data),
        .ch_ready(ready_j), .mute(mute), .pdm_value(pdm_j),
        .sample_strobe(strobe_j), .busy(busy_j)
    );

    pdm_mix_scheduler #(.VALUE_BITS(VB), .NUM_CH(NCH), .SAMPLE_DIV(DIV), .RAMP_STEP(4)) dut_ramp (
        .clk(clk), .reset(reset), .ch_valid(ch_valid), .ch_data(ch_data),
        .ch_ready(ready_r), .mute(mute), .pdm_value(pdm_r),
        .sample_strobe(strobe_r), .busy(busy_r)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0d, expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int n);
        while (cyc < n)
            step();
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
        cyc   = 0;
    endtask

    initial begin
        reset    = 1'b1;
        ch_valid = '0;
        ch_data  = '0;
        mute     = 1'b0;
        @(posedge clk);
        @(posedge clk);
        release_reset();

        // Idle run: no input, output stays 0, strobes on schedule.
        chk("reset_ready", ready_j, 7);
        chk("reset_pdm", pdm_j, 0);
        chk("reset_strobe", strobe_j, 0);
        chk("reset_busy", busy_j, 0);
        goto(15); chk("busy_tick", busy_j, 0);
        goto(16); chk("busy_sum0", busy_j, 1);
        goto(19); chk("busy_update", busy_j, 1);
        chk("strobe_early", strobe_j, 0);
        goto(20); chk("strobe_first", strobe_j, 1);
        chk("pdm_idle", pdm_j, 0);
        chk("busy_after", busy_j, 0);
        goto(21); chk("strobe_pulse", strobe_j, 0);
        goto(36); chk("strobe_second", strobe_j, 1);

        // Basic mix 10+20+30.
        goto(37);
        ch_valid = 3'b111;
        ch_data  = {8'd30, 8'd20, 8'd10};
        step();
        ch_valid = '0;
        chk("ready_after_accept", ready_j, 0);
        goto(49); chk("ready_sum_ch0", ready_j, 1);
        goto(50); chk("ready_sum_ch1", ready_j, 3);
        goto(51); chk("ready_sum_all", ready_j, 7);
        goto(52); chk("mix_strobe", strobe_j, 1);
        chk("mix_60", pdm_j, 60);

        // Saturation, then reuse of held values.
        goto(53);
        ch_valid = 3'b111;
        ch_data  = {8'd50, 8'd100, 8'd200};
        step();
        ch_valid = '0;
        goto(68); chk("mix_sat", pdm_j, 255);
        goto(69);
        ch_valid = 3'b001;
        ch_data  = '0;
        step();
        ch_valid = '0;
        goto(84); chk("mix_reuse", pdm_j, 150);

        // Backpressure on channel 0.
        goto(85);
        ch_valid = 3'b111;
        ch_data  = {8'd0, 8'd0, 8'd5};
        step();
        ch_valid = 3'b001;
        ch_data  = 24'd7;
        chk("bp_ready_low", ready_j[0], 0);
        goto(96); chk("bp_ready_sum", ready_j[0], 0);
        goto(97); chk("bp_ready_free", ready_j[0], 1);
        goto(98);
        ch_valid = '0;
        chk("bp_accepted", ready_j[0], 0);
        goto(100); chk("bp_first", pdm_j, 5);
        goto(116); chk("bp_second", pdm_j, 7);

        // Reset during the second SUM cycle.
        goto(145);
        chk("mid_busy", busy_j, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_pdm", pdm_j, 0);
        chk("mid_rst_busy", busy_j, 0);
        chk("mid_rst_strobe", strobe_j, 0);
        chk("mid_rst_pdm_ramp", pdm_r, 0);
        @(posedge clk);
        release_reset();
        chk("rel_ready", ready_j, 7);
        goto(19); chk("rel_no_strobe", strobe_j, 0);
        goto(20); chk("rel_strobe", strobe_j, 1);
        chk("rel_pdm", pdm_j, 0);

        // Ramp toward 10, mute down to 0, unmute back to 10.
        goto(21);
        ch_valid = 3'b001;
        ch_data  = 24'd10;
        step();
        ch_valid = '0;
        goto(36);  chk("ramp_up1", pdm_r, 4);
        chk("jump_up", pdm_j, 10);
        goto(52);  chk("ramp_up2", pdm_r, 8);
        goto(68);  chk("ramp_up3", pdm_r, 10);
        goto(69);  mute = 1'b1;
        goto(84);  chk("ramp_mute1", pdm_r, 6);
        chk("jump_mute", pdm_j, 0);
        goto(100); chk("ramp_mute2", pdm_r, 2);
        goto(116); chk("ramp_mute3", pdm_r, 0);
        goto(117); mute = 1'b0;
        goto(132); chk("ramp_unmute1", pdm_r, 4);
        goto(148); chk("ramp_unmute2", pdm_r, 8);
        goto(164); chk("ramp_unmute3", pdm_r, 10);
        chk("ramp_strobe", strobe_r, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
